// File: rtl/coretest_host.sv
// coretest_host: host-side initiator that frames read/write/reset requests for a coretest peer and parses the reply.
module coretest_host #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  cmd,
    input  logic [15:0] address,
    input  logic [31:0] write_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  resp_code,
    output logic [31:0] read_data,
    output logic        tx_syn,
    output logic [7:0]  tx_data,
    input  logic        tx_ack,
    input  logic        rx_syn,
    input  logic [7:0]  rx_data,
    output logic        rx_ack
);
    typedef enum logic [2:0] {IDLE, SEND, SGAP, RECV, RGAP, DONE} state_t;

    state_t      state, state_nxt;
    logic [1:0]  cmd_q;
    logic [15:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rbuf;
    logic [31:0] tcnt;
    logic [3:0]  idx;
    logic [3:0]  rlen;
    logic        last;
    logic [7:0]  cmd_byte;
    logic [7:0]  ok_code;
    logic [7:0]  tx_byte;
    logic [3:0]  tx_len;
    logic [3:0]  rsp_len;
    logic        rx_take;
    logic        timeout;

    always_comb begin
        cmd_byte = cmd_q == 2'b00 ? 8'h10 : cmd_q == 2'b01 ? 8'h11 : cmd_q == 2'b10 ? 8'h01 : 8'hFF;
        ok_code  = cmd_q == 2'b00 ? 8'h7F : cmd_q == 2'b01 ? 8'h7E : cmd_q == 2'b10 ? 8'h7D : 8'h00;
        tx_len   = cmd_q == 2'b00 ? 4'd5 : cmd_q == 2'b01 ? 4'd9 : 4'd3;
        tx_byte  = idx == 4'd0 ? 8'h55 :
                   idx == 4'd1 ? cmd_byte :
                   idx == tx_len - 4'd1 ? 8'hAA :
                   idx == 4'd2 ? addr_q[15:8] :
                   idx == 4'd3 ? addr_q[7:0] :
                   idx == 4'd4 ? wdata_q[31:24] :
                   idx == 4'd5 ? wdata_q[23:16] :
                   idx == 4'd6 ? wdata_q[15:8] : wdata_q[7:0];
        // A zero length marks an unknown response code
        rsp_len  = rx_data == 8'h7F ? 4'd9 :
                   rx_data == 8'h7E ? 4'd5 :
                   rx_data == 8'h7D ? 4'd3 :
                   (rx_data == 8'hFE || rx_data == 8'hFD) ? 4'd4 : 4'd0;
    end

    assign rx_take = state == RECV && rx_syn;
    assign timeout = ((state == SEND && !tx_ack) || (state == RECV && !rx_syn))
                     && tcnt == TIMEOUT_CYCLES - 32'd1;
    assign busy    = state == SEND || state == SGAP || state == RECV || state == RGAP;
    assign done    = state == DONE;
    assign tx_syn  = state == SEND;
    assign tx_data = tx_syn ? tx_byte : 8'h00;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: state_nxt = start ? SEND : IDLE;
            SEND: state_nxt = timeout ? DONE : tx_ack ? SGAP : SEND;
            SGAP: state_nxt = idx == tx_len - 4'd1 ? RECV : SEND;
            RECV: state_nxt = rx_syn ? RGAP : timeout ? DONE : RECV;
            RGAP: state_nxt = last ? DONE : RECV;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            cmd_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rbuf      <= '0;
            tcnt      <= '0;
            idx       <= '0;
            rlen      <= '0;
            last      <= 1'b0;
            error     <= 1'b0;
            resp_code <= '0;
            read_data <= '0;
            rx_ack    <= 1'b0;
        end else begin
            tcnt   <= (state_nxt != state || state == IDLE) ? 32'd0 : tcnt + 32'd1;
            rx_ack <= rx_take;
            if (state == IDLE && start) begin
                cmd_q     <= cmd;
                addr_q    <= address;
                wdata_q   <= write_data;
                error     <= 1'b0;
                resp_code <= '0;
                idx       <= '0;
                last      <= 1'b0;
            end
            if (state == SGAP)
                idx <= idx == tx_len - 4'd1 ? 4'd0 : idx + 4'd1;
            if (timeout) begin
                error     <= 1'b1;
                resp_code <= '0;
            end
            // Bad SOR and unknown codes make the current byte the last one
            if (rx_take) begin
                idx <= idx + 4'd1;
                if (idx == 4'd0) begin
                    last <= rx_data != 8'hAA;
                    if (rx_data != 8'hAA) begin
                        error     <= 1'b1;
                        resp_code <= '0;
                    end
                end else if (idx == 4'd1) begin
                    resp_code <= rx_data;
                    rlen      <= rsp_len;
                    last      <= rsp_len == 4'd0;
                    if (rx_data != ok_code || rsp_len == 4'd0) error <= 1'b1;
                end else begin
                    last <= idx == rlen - 4'd1;
                    if (idx == rlen - 4'd1) begin
                        if (rx_data != 8'h55) error <= 1'b1;
                        else if (!error && resp_code == 8'h7F) read_data <= rbuf;
                    end else if ((resp_code == 8'h7F || resp_code == 8'h7E) && idx < 4'd4) begin
                        if (rx_data != (idx == 4'd2 ? addr_q[15:8] : addr_q[7:0])) error <= 1'b1;
                    end else if (resp_code == 8'h7F) begin
                        rbuf <= {rbuf[23:0], rx_data};
                    end
                end
            end
        end
endmodule

// File: tb/tb_coretest_host.sv
// tb_coretest_host: scoreboard bench with peer models driving the syn/ack links of coretest_host.
module tb_coretest_host;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  cmd = 2'b00;
    logic [15:0] address = '0;
    logic [31:0] write_data = '0;
    logic        busy, done, error;
    logic [7:0]  resp_code;
    logic [31:0] read_data;
    logic        tx_syn;
    logic [7:0]  tx_data;
    logic        tx_ack = 1'b0;
    logic        rx_syn = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_ack;

    typedef struct {
        logic        err;
        logic [7:0]  code;
        logic [31:0] data;
    } res_t;

    logic [7:0] exp_tx[$];
    logic [7:0] rx_q[$];
    res_t       exp_res[$];
    int         n_checks = 0;
    int         n_fail = 0;
    logic       ack_en = 1'b1;

    coretest_host #(.TIMEOUT_CYCLES(32'd16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .cmd(cmd), .address(address),
        .write_data(write_data), .busy(busy), .done(done), .error(error),
        .resp_code(resp_code), .read_data(read_data), .tx_syn(tx_syn), .tx_data(tx_data),
        .tx_ack(tx_ack), .rx_syn(rx_syn), .rx_data(rx_data), .rx_ack(rx_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Command-side peer: acks each byte one cycle after seeing it and checks it
    initial forever begin
        @(negedge clk);
        if (tx_ack) tx_ack = 1'b0;
        else if (tx_syn && ack_en && reset_n) begin
            if (exp_tx.size() == 0) chk("tx_unexpected", {24'h0, tx_data}, 32'hxx);
            else chk("tx_byte", {24'h0, tx_data}, {24'h0, exp_tx.pop_front()});
            tx_ack = 1'b1;
        end
    end

    // Response-side peer: presents queued bytes, withdraws once acked
    initial forever begin
        @(negedge clk);
        if (rx_syn && rx_ack) rx_syn = 1'b0;
        else if (!rx_syn && rx_q.size() != 0) begin
            rx_data = rx_q.pop_front();
            rx_syn  = 1'b1;
        end
    end

    // Result monitor
    initial forever begin
        @(negedge clk);
        if (done) begin
            if (exp_res.size() == 0) chk("done_unexpected", {31'h0, done}, 32'h0);
            else begin
                res_t r;
                r = exp_res.pop_front();
                chk("error", {31'h0, error}, {31'h0, r.err});
                chk("resp_code", {24'h0, resp_code}, {24'h0, r.code});
                chk("read_data", read_data, r.data);
            end
        end
    end

    task automatic txn(input logic [1:0] c, input logic [15:0] a, input logic [31:0] d);
        int n;
        @(negedge clk);
        cmd = c; address = a; write_data = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_c1", {31'h0, busy}, 32'h1);
        chk("tx_syn_c1", {31'h0, tx_syn}, 32'h1);
        chk("tx_data_c1", {24'h0, tx_data}, 32'h55);
        n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("txn_bound", {31'h0, n < 500}, 32'h1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int cyc;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_tx_syn", {31'h0, tx_syn}, 32'h0);
        chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
        chk("rst_resp", {24'h0, resp_code}, 32'h0);
        chk("rst_rdata", read_data, 32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        exp_tx = '{8'h55, 8'h11, 8'h10, 8'h08, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hAA};
        rx_q   = '{8'hAA, 8'h7E, 8'h10, 8'h08, 8'h55};
        exp_res.push_back('{1'b0, 8'h7E, 32'h0});
        txn(2'b01, 16'h1008, 32'hDEADBEEF);

        exp_tx = '{8'h55, 8'h10, 8'h00, 8'h02, 8'hAA};
        rx_q   = '{8'hAA, 8'h7F, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h55};
        exp_res.push_back('{1'b0, 8'h7F, 32'h12345678});
        txn(2'b00, 16'h0002, 32'h0);

        exp_tx = '{8'h55, 8'hFF, 8'hAA};
        rx_q   = '{8'hAA, 8'hFE, 8'hFF, 8'h55};
        exp_res.push_back('{1'b1, 8'hFE, 32'h12345678});
        txn(2'b11, 16'h0000, 32'h0);

        exp_tx = '{8'h55, 8'h10, 8'h00, 8'h02, 8'hAA};
        rx_q   = '{8'hAA, 8'h7F, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        exp_res.push_back('{1'b1, 8'h7F, 32'h12345678});
        txn(2'b00, 16'h0002, 32'h0);

        exp_tx = '{8'h55, 8'h10, 8'h00, 8'h02, 8'hAA};
        rx_q   = '{8'hAA, 8'h7F, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
        exp_res.push_back('{1'b1, 8'h7F, 32'h12345678});
        txn(2'b00, 16'h0002, 32'h0);

        exp_tx = '{8'h55, 8'h01, 8'hAA};
        rx_q   = '{8'hAA, 8'h7D, 8'h55};
        exp_res.push_back('{1'b0, 8'h7D, 32'h12345678});
        txn(2'b10, 16'h0000, 32'h0);

        exp_tx = '{8'h55, 8'h10, 8'h00, 8'h05, 8'hAA};
        rx_q   = '{8'h00};
        exp_res.push_back('{1'b1, 8'h00, 32'h12345678});
        txn(2'b00, 16'h0005, 32'h0);

        ack_en = 1'b0;
        exp_res.push_back('{1'b1, 8'h00, 32'h12345678});
        @(negedge clk);
        cmd = 2'b00; address = 16'h0040; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 100) begin
            if (cyc == 4) begin cmd = 2'b01; start = 1'b1; end
            if (cyc == 5) start = 1'b0;
            if (cyc == 10) begin
                chk("to_tx_syn", {31'h0, tx_syn}, 32'h1);
                chk("to_tx_data", {24'h0, tx_data}, 32'h55);
            end
            @(negedge clk);
            cyc++;
        end
        chk("timeout_cycle", cyc, 32'd17);
        repeat (3) @(negedge clk);
        chk("ignored_start", {31'h0, busy}, 32'h0);

        @(negedge clk);
        cmd = 2'b00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy", {31'h0, busy}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk("mr_busy", {31'h0, busy}, 32'h0);
        chk("mr_tx_syn", {31'h0, tx_syn}, 32'h0);
        chk("mr_tx_data", {24'h0, tx_data}, 32'h0);
        chk("mr_error", {31'h0, error}, 32'h0);
        chk("mr_rdata", read_data, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_busy", {31'h0, busy}, 32'h0);

        chk("tx_left", exp_tx.size(), 32'd0);
        chk("res_left", exp_res.size(), 32'd0);
        chk("rx_left", rx_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
